mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single memory port between instruction fetch (read-only) and the MEM stage (load/store).
- Sequences one outstanding bus transaction at a time and returns responses to the owning requester.
- Drives per-requester stall outputs to the pipeline controller.
- Arbitration gives data priority, with a bounded-starvation guarantee for fetch.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, memory data width.
- STARVE_LIMIT, 4, arbitration losses by fetch before fetch is forced to win. 0 means strict data priority.

Ports:
- clock  in  1  single clock
- reset  in  1  asynchronous, active-high reset
- i_req_i  in  1  fetch request, held until i_ready_o
- i_addr_i  in  ADDR_W  fetch address, 4-byte aligned
- i_ready_o  out  1  one-cycle fetch completion pulse
- i_rdata_o  out  32  fetched instruction
- d_req_i  in  1  data request, held until d_ready_o
- d_we_i  in  1  1 = store
- d_addr_i  in  ADDR_W  data address
- d_wdata_i  in  DATA_W  store data
- d_wstrb_i  in  DATA_W/8  byte strobes
- d_ready_o  out  1  one-cycle data completion pulse
- d_rdata_o  out  DATA_W  load data
- flush_i  in  1  discard in-flight fetch response
- m_req_o  out  1  bus request
- m_we_o  out  1  bus write
- m_addr_o  out  ADDR_W  bus address
- m_wdata_o  out  DATA_W  bus write data
- m_wstrb_o  out  DATA_W/8  bus strobes
- m_gnt_i  in  1  bus accepts request
- m_rvalid_i  in  1  bus response or write acknowledge
- m_rdata_i  in  DATA_W  bus read data
- if_stall_o  out  1  i_req_i & ~i_ready_o (combinational)
- mem_stall_o  out  1  d_req_i & ~d_ready_o (combinational)

Behaviour:
- Reset (async, clock-independent) forces:
  - state IDLE; all registered outputs 0; starvation counter 0; discard flag 0.
  - m_rvalid_i arriving after reset is ignored.
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE:
  - If either request is pending, select a winner and latch owner plus its addr/we/wdata/wstrb; go to REQ.
  - Winner selection: data wins unless (starve_cnt == STARVE_LIMIT and i_req_i), in which case fetch wins.
  - Fetch-only: fetch wins. Data-only: data wins.
- REQ:
  - m_req_o = 1, bus fields driven from latched registers.
  - When m_gnt_i is high, go to RESP.
  - m_rvalid_i is ignored in this state.
- RESP:
  - m_req_o = 0. On m_rvalid_i, capture m_rdata_i and go to DONE.
  - Stores also wait for m_rvalid_i.
- DONE:
  - Pulse the owner's ready for exactly 1 cycle, then go to IDLE.
  - i_rdata_o = captured word [63:32] if addr[2], else [31:0].
  - Ready outputs are 0 in every other state.
  - rdata outputs hold their last captured value.
- Minimum latency: request sampled at cycle 0, m_req_o high at cycle 1, m_gnt_i same cycle, m_rvalid_i at cycle 2, ready pulse at cycle 3.
- Back-to-back requests from the same master: the new request is sampled in the IDLE cycle after DONE.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) whenever fetch loses an IDLE arbitration while i_req_i is high.
  - Clears when fetch wins.
- flush_i:
  - If the owner is fetch in REQ, RESP or DONE, set the discard flag. The bus transaction completes normally, but i_ready_o is suppressed.
  - The flag clears on return to IDLE.
  - flush_i in IDLE has no effect; an ungranted fetch simply re-arbitrates with whatever request is then presented.
  - Data transactions are never discarded.
- Simultaneous flush_i and m_rvalid_i while fetch owns RESP: the response is discarded.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- When defined, adds 64-bit outputs:
  - perf_conflict_o: cycles in IDLE with both requests high.
  - perf_busy_o: cycles not in IDLE.
  - Both clear on reset and wrap at 2^64.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package arb_pkg:
  - State enum (IDLE/REQ/RESP/DONE).
  - Owner enum (OWN_I/OWN_D).
  - Fetch word-select constant (bit 2).
- Sub-module arb_select: combinational winner selection plus the starvation counter register. This isolates the fairness logic for unit testing.

Test Plan:
- Fetch-only read of 0x80000000, memory returns 0x00000013_00100093 at cycle 2 -> i_ready_o pulse at cycle 3, i_rdata_o = 0x00100093; if_stall_o high for cycles 0-2.
- Both requests at cycle 0, memory with 0-wait gnt -> data served first (d_ready_o at cycle 3), then fetch (i_ready_o at cycle 7); mem_stall_o low from cycle 4.
- d_req_i held continuously with new requests each time, STARVE_LIMIT=4, i_req_i high -> fetch wins the 5th arbitration; counter reads 0 afterwards.
- Fetch granted, flush_i at cycle 2, rvalid at cycle 4 -> no i_ready_o; the next data request is served normally.
- Store of 0xDEADBEEF with wstrb 0x0F, gnt delayed 3 cycles -> m_req_o, m_addr_o and m_wdata_o stable until gnt; d_ready_o one cycle after rvalid.
- Reset asserted mid-RESP, then rvalid arrives -> outputs 0, state IDLE, rvalid ignored, no ready pulse.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types for the instruction/data memory port arbiter.
// Holds FSM states, owner tags and the fetch word-select bit.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    DONE
  } state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_t;

  localparam int FETCH_SEL_BIT = 2;

  function automatic int cnt_w(int lim);
    return (lim < 1) ? 1 : $clog2(lim + 1);
  endfunction

endpackage

// File: rtl/arb_select.sv
// Winner selection for the memory port: data first, fetch forced
// after STARVE_LIMIT consecutive losses (0 = strict data priority).
module arb_select
  import arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic i_req,
  input  logic d_req,
  input  logic arb_en,
  output logic win_i
);

  localparam int CNT_W = cnt_w(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;
  logic             forced;

  assign forced = (STARVE_LIMIT != 0) && (starve_cnt == LIM);
  assign win_i  = i_req && (!d_req || forced);

  // Count fetch losses while it waits; saturate, clear when fetch wins.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (arb_en) begin
      if (win_i) begin
        starve_cnt <= '0;
      end else if (i_req && (starve_cnt != LIM)) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single memory port shared by fetch and MEM, one transaction at a time.
// Define ARB_PERF_CNT_EN to add conflict/busy performance counters.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                i_req_i,
  input  logic [ADDR_W-1:0]   i_addr_i,
  output logic                i_ready_o,
  output logic [31:0]         i_rdata_o,
  input  logic                d_req_i,
  input  logic                d_we_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W-1:0]   d_wdata_i,
  input  logic [DATA_W/8-1:0] d_wstrb_i,
  output logic                d_ready_o,
  output logic [DATA_W-1:0]   d_rdata_o,
  input  logic                flush_i,
  output logic                m_req_o,
  output logic                m_we_o,
  output logic [ADDR_W-1:0]   m_addr_o,
  output logic [DATA_W-1:0]   m_wdata_o,
  output logic [DATA_W/8-1:0] m_wstrb_o,
  input  logic                m_gnt_i,
  input  logic                m_rvalid_i,
  input  logic [DATA_W-1:0]   m_rdata_i,
`ifdef ARB_PERF_CNT_EN
  output logic [63:0]         perf_conflict_o,
  output logic [63:0]         perf_busy_o,
`endif
  output logic                if_stall_o,
  output logic                mem_stall_o
);

  state_t                state;
  owner_t                owner;
  logic [ADDR_W-1:0]     addr_q;
  logic                  we_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W/8-1:0]   wstrb_q;
  logic                  req_q;
  logic                  discard_q;
  logic                  i_ready_q;
  logic                  d_ready_q;
  logic [31:0]           i_rdata_q;
  logic [DATA_W-1:0]     d_rdata_q;
  logic                  win_i;
  logic                  arb_en;
  logic                  own_i;
  logic                  drop;

  assign arb_en = (state == IDLE) && (i_req_i || d_req_i);
  assign own_i  = (owner == OWN_I);
  assign drop   = discard_q || flush_i;

  arb_select #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_sel (
    .clock (clock),
    .reset (reset),
    .i_req (i_req_i),
    .d_req (d_req_i),
    .arb_en(arb_en),
    .win_i (win_i)
  );

  // Transaction sequencer: latch winner, request, wait response, pulse ready.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= OWN_I;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      req_q     <= 1'b0;
      discard_q <= 1'b0;
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      unique case (state)
        IDLE: begin
          discard_q <= 1'b0;
          if (i_req_i || d_req_i) begin
            owner   <= win_i ? OWN_I : OWN_D;
            addr_q  <= win_i ? i_addr_i : d_addr_i;
            we_q    <= win_i ? 1'b0 : d_we_i;
            wdata_q <= win_i ? '0 : d_wdata_i;
            wstrb_q <= win_i ? '0 : d_wstrb_i;
            req_q   <= 1'b1;
            state   <= REQ;
          end
        end
        REQ: begin
          if (own_i && flush_i) discard_q <= 1'b1;
          if (m_gnt_i) begin
            req_q <= 1'b0;
            state <= RESP;
          end
        end
        RESP: begin
          if (own_i && flush_i) discard_q <= 1'b1;
          if (m_rvalid_i) begin
            state <= DONE;
            if (own_i) begin
              if (!drop) begin
                i_ready_q <= 1'b1;
                i_rdata_q <= addr_q[FETCH_SEL_BIT] ?
                             m_rdata_i[32 +: 32] :
                             m_rdata_i[0 +: 32];
              end
            end else begin
              d_ready_q <= 1'b1;
              d_rdata_q <= m_rdata_i;
            end
          end
        end
        DONE: begin
          discard_q <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [63:0] conflict_q;
  logic [63:0] busy_q;

  // Free-running, wrapping utilisation counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      conflict_q <= '0;
      busy_q     <= '0;
    end else begin
      if ((state == IDLE) && i_req_i && d_req_i)
        conflict_q <= conflict_q + 64'd1;
      if (state != IDLE)
        busy_q <= busy_q + 64'd1;
    end
  end

  assign perf_conflict_o = conflict_q;
  assign perf_busy_o     = busy_q;
`endif

  assign m_req_o     = req_q;
  assign m_we_o      = we_q;
  assign m_addr_o    = addr_q;
  assign m_wdata_o   = wdata_q;
  assign m_wstrb_o   = wstrb_q;
  assign i_ready_o   = i_ready_q && !flush_i;
  assign d_ready_o   = d_ready_q;
  assign i_rdata_o   = i_rdata_q;
  assign d_rdata_o   = d_rdata_q;
  assign if_stall_o  = i_req_i && !i_ready_o;
  assign mem_stall_o = d_req_i && !d_ready_o;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small bus responder.
// Cycle c means the period after the c-th sampling edge.
module tb_mem_port_arbiter;
  import arb_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        i_req_i;
  logic [63:0] i_addr_i;
  logic        i_ready_o;
  logic [31:0] i_rdata_o;
  logic        d_req_i;
  logic        d_we_i;
  logic [63:0] d_addr_i;
  logic [63:0] d_wdata_i;
  logic [7:0]  d_wstrb_i;
  logic        d_ready_o;
  logic [63:0] d_rdata_o;
  logic        flush_i;
  logic        m_req_o;
  logic        m_we_o;
  logic [63:0] m_addr_o;
  logic [63:0] m_wdata_o;
  logic [7:0]  m_wstrb_o;
  logic        m_gnt_i = 1'b0;
  logic        m_rvalid_i = 1'b0;
  logic [63:0] m_rdata_i = '0;
  logic        if_stall_o;
  logic        mem_stall_o;
`ifdef ARB_PERF_CNT_EN
  logic [63:0] perf_conflict_o;
  logic [63:0] perf_busy_o;
`endif

  int checks = 0;
  int errors = 0;

  bit          auto_en = 1'b1;
  bit          man_gnt = 1'b0;
  bit          man_rvalid = 1'b0;
  int          gnt_wait = 0;
  int          rsp_wait = 0;
  int          gc = 0;
  int          rc = 0;
  bit          pend = 1'b0;
  logic [63:0] rsp_data = '0;

  mem_port_arbiter dut (
    .clock          (clock),
    .reset          (reset),
    .i_req_i        (i_req_i),
    .i_addr_i       (i_addr_i),
    .i_ready_o      (i_ready_o),
    .i_rdata_o      (i_rdata_o),
    .d_req_i        (d_req_i),
    .d_we_i         (d_we_i),
    .d_addr_i       (d_addr_i),
    .d_wdata_i      (d_wdata_i),
    .d_wstrb_i      (d_wstrb_i),
    .d_ready_o      (d_ready_o),
    .d_rdata_o      (d_rdata_o),
    .flush_i        (flush_i),
    .m_req_o        (m_req_o),
    .m_we_o         (m_we_o),
    .m_addr_o       (m_addr_o),
    .m_wdata_o      (m_wdata_o),
    .m_wstrb_o      (m_wstrb_o),
    .m_gnt_i        (m_gnt_i),
    .m_rvalid_i     (m_rvalid_i),
    .m_rdata_i      (m_rdata_i),
`ifdef ARB_PERF_CNT_EN
    .perf_conflict_o(perf_conflict_o),
    .perf_busy_o    (perf_busy_o),
`endif
    .if_stall_o     (if_stall_o),
    .mem_stall_o    (mem_stall_o)
  );

  always #5 clock = ~clock;

  // Bus responder: grant after gnt_wait cycles, respond rsp_wait later.
  always @(negedge clock) begin
    m_gnt_i    = 1'b0;
    m_rvalid_i = 1'b0;
    if (!auto_en) begin
      m_gnt_i    = man_gnt;
      m_rvalid_i = man_rvalid;
      m_rdata_i  = rsp_data;
      pend       = 1'b0;
      gc         = 0;
    end else if (reset) begin
      pend = 1'b0;
      gc   = 0;
    end else if (m_req_o) begin
      if (gc >= gnt_wait) begin
        m_gnt_i = 1'b1;
        gc      = 0;
        pend    = 1'b1;
        rc      = 0;
      end else begin
        gc++;
      end
    end else if (pend) begin
      if (rc >= rsp_wait) begin
        m_rvalid_i = 1'b1;
        m_rdata_i  = rsp_data;
        pend       = 1'b0;
      end else begin
        rc++;
      end
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs;
    i_req_i   = 1'b0;
    i_addr_i  = '0;
    d_req_i   = 1'b0;
    d_we_i    = 1'b0;
    d_addr_i  = '0;
    d_wdata_i = '0;
    d_wstrb_i = '0;
    flush_i   = 1'b0;
  endtask

  task automatic do_reset;
    reset      = 1'b1;
    idle_inputs();
    auto_en    = 1'b1;
    man_gnt    = 1'b0;
    man_rvalid = 1'b0;
    gnt_wait   = 0;
    rsp_wait   = 0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if (m_req_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_m_req got %0b want 0", m_req_o);
    end
    checks++;
    if ({i_ready_o, d_ready_o} !== 2'b00) begin
      errors++;
      $display("FAIL reset_ready got %b want 00", {i_ready_o, d_ready_o});
    end
    checks++;
    if (i_rdata_o !== 32'h0 || d_rdata_o !== 64'h0) begin
      errors++;
      $display("FAIL reset_rdata got %h/%h want 0", i_rdata_o, d_rdata_o);
    end
    checks++;
    if (dut.state !== IDLE) begin
      errors++;
      $display("FAIL reset_state got %0d want IDLE", dut.state);
    end
    checks++;
    if ({if_stall_o, mem_stall_o} !== 2'b00) begin
      errors++;
      $display("FAIL reset_stall got %b want 00", {if_stall_o, mem_stall_o});
    end
  endtask

  task automatic test_fetch;
    do_reset();
    rsp_data = 64'h00000013_00100093;
    i_req_i  = 1'b1;
    i_addr_i = 64'h8000_0000;
    #1;
    checks++;
    if (if_stall_o !== 1'b1) begin
      errors++;
      $display("FAIL fetch_stall_c0 got %0b want 1", if_stall_o);
    end
    for (int c = 1; c <= 4; c++) begin
      tick();
      checks++;
      if (i_ready_o !== (c == 3)) begin
        errors++;
        $display("FAIL fetch_ready c%0d got %0b want %0b", c, i_ready_o, c == 3);
      end
      checks++;
      if (c <= 3 && if_stall_o !== (c != 3)) begin
        errors++;
        $display("FAIL fetch_stall c%0d got %0b want %0b", c, if_stall_o, c != 3);
      end
      if (c == 1) begin
        checks++;
        if (m_req_o !== 1'b1 || m_addr_o !== 64'h8000_0000 || m_we_o !== 1'b0) begin
          errors++;
          $display("FAIL fetch_bus c1 got req=%0b addr=%h we=%0b want 1/80000000/0",
                   m_req_o, m_addr_o, m_we_o);
        end
      end
      if (c == 3) begin
        checks++;
        if (i_rdata_o !== 32'h0010_0093) begin
          errors++;
          $display("FAIL fetch_rdata got %h want 00100093", i_rdata_o);
        end
        i_req_i = 1'b0;
      end
    end
  endtask

  task automatic test_upper_word;
    bit got = 1'b0;
    do_reset();
    rsp_data = 64'h11112222_33334444;
    i_req_i  = 1'b1;
    i_addr_i = 64'h8000_0004;
    for (int k = 0; k < 20 && !got; k++) begin
      tick();
      if (i_ready_o) got = 1'b1;
    end
    i_req_i = 1'b0;
    checks++;
    if (!got || i_rdata_o !== 32'h1111_2222) begin
      errors++;
      $display("FAIL upper_word got ready=%0b data=%h want 1/11112222", got, i_rdata_o);
    end
  endtask

  task automatic test_both;
    do_reset();
    rsp_data = 64'hAAAA_BBBB_CCCC_DDDD;
    i_req_i  = 1'b1;
    i_addr_i = 64'h8000_0000;
    d_req_i  = 1'b1;
    d_we_i   = 1'b0;
    d_addr_i = 64'h1000;
    for (int c = 1; c <= 8; c++) begin
      tick();
      checks++;
      if (d_ready_o !== (c == 3) || i_ready_o !== (c == 7)) begin
        errors++;
        $display("FAIL both_ready c%0d got d=%0b i=%0b want d=%0b i=%0b",
                 c, d_ready_o, i_ready_o, c == 3, c == 7);
      end
      if (c >= 4) begin
        checks++;
        if (mem_stall_o !== 1'b0) begin
          errors++;
          $display("FAIL both_mem_stall c%0d got 1 want 0", c);
        end
      end
      if (c == 1 || c == 5) begin
        checks++;
        if (m_addr_o !== ((c == 1) ? 64'h1000 : 64'h8000_0000)) begin
          errors++;
          $display("FAIL both_addr c%0d got %h", c, m_addr_o);
        end
      end
      if (c == 2) begin
        checks++;
        if (dut.u_sel.starve_cnt !== 3'd1) begin
          errors++;
          $display("FAIL both_starve got %0d want 1", dut.u_sel.starve_cnt);
        end
      end
      if (c == 3) begin
        checks++;
        if (d_rdata_o !== 64'hAAAA_BBBB_CCCC_DDDD) begin
          errors++;
          $display("FAIL both_drdata got %h want aaaabbbbccccdddd", d_rdata_o);
        end
        d_req_i  = 1'b0;
        rsp_data = 64'h0000_0000_1234_5678;
      end
      if (c == 7) begin
        checks++;
        if (i_rdata_o !== 32'h1234_5678) begin
          errors++;
          $display("FAIL both_irdata got %h want 12345678", i_rdata_o);
        end
        i_req_i = 1'b0;
      end
    end
  endtask

  task automatic test_starve;
    bit got = 1'b0;
    int dcnt = 0;
    int maxc = 0;
    do_reset();
    rsp_data = 64'h1;
    i_req_i  = 1'b1;
    i_addr_i = 64'h8000_0100;
    d_req_i  = 1'b1;
    d_addr_i = 64'h2000;
    for (int k = 0; k < 80 && !got; k++) begin
      tick();
      if (int'(dut.u_sel.starve_cnt) > maxc) maxc = int'(dut.u_sel.starve_cnt);
      if (d_ready_o) begin
        dcnt++;
        d_addr_i = d_addr_i + 64'd8;
      end
      if (i_ready_o) got = 1'b1;
    end
    idle_inputs();
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL starve_timeout got no i_ready want pulse");
    end
    checks++;
    if (dcnt !== 4) begin
      errors++;
      $display("FAIL starve_dcount got %0d want 4", dcnt);
    end
    checks++;
    if (maxc !== 4) begin
      errors++;
      $display("FAIL starve_max got %0d want 4", maxc);
    end
    checks++;
    if (dut.u_sel.starve_cnt !== 3'd0) begin
      errors++;
      $display("FAIL starve_clear got %0d want 0", dut.u_sel.starve_cnt);
    end
    tick();
  endtask

  task automatic test_flush;
    bit got = 1'b0;
    do_reset();
    rsp_wait = 2;
    rsp_data = 64'hFFFF_EEEE_DDDD_CCCC;
    i_req_i  = 1'b1;
    i_addr_i = 64'h8000_0010;
    tick();
    tick();
    flush_i = 1'b1;
    i_req_i = 1'b0;
    for (int c = 3; c <= 8; c++) begin
      tick();
      flush_i = 1'b0;
      checks++;
      if (i_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL flush_ready c%0d got 1 want 0", c);
      end
      if (c == 5) begin
        checks++;
        if (dut.state !== DONE) begin
          errors++;
          $display("FAIL flush_done c5 got %0d want DONE", dut.state);
        end
      end
    end
    rsp_wait = 0;
    rsp_data = 64'h0000_0000_0000_0055;
    d_req_i  = 1'b1;
    d_addr_i = 64'h3000;
    for (int k = 0; k < 20 && !got; k++) begin
      tick();
      if (d_ready_o) got = 1'b1;
    end
    d_req_i = 1'b0;
    checks++;
    if (!got || d_rdata_o !== 64'h55) begin
      errors++;
      $display("FAIL flush_next_data got ready=%0b data=%h want 1/55", got, d_rdata_o);
    end
    checks++;
    if (i_rdata_o !== 32'h0) begin
      errors++;
      $display("FAIL flush_irdata got %h want 0", i_rdata_o);
    end
  endtask

  task automatic test_store;
    do_reset();
    gnt_wait  = 3;
    rsp_data  = '0;
    d_req_i   = 1'b1;
    d_we_i    = 1'b1;
    d_addr_i  = 64'h4008;
    d_wdata_i = 64'hDEAD_BEEF;
    d_wstrb_i = 8'h0F;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c <= 4) begin
        checks++;
        if (m_req_o !== 1'b1 || m_addr_o !== 64'h4008 ||
            m_wdata_o !== 64'hDEAD_BEEF || m_we_o !== 1'b1 ||
            m_wstrb_o !== 8'h0F) begin
          errors++;
          $display("FAIL store_bus c%0d got req=%0b addr=%h wd=%h we=%0b st=%h",
                   c, m_req_o, m_addr_o, m_wdata_o, m_we_o, m_wstrb_o);
        end
      end
      if (c == 5) begin
        checks++;
        if (m_req_o !== 1'b0) begin
          errors++;
          $display("FAIL store_req_drop c5 got 1 want 0");
        end
      end
      checks++;
      if (d_ready_o !== (c == 6)) begin
        errors++;
        $display("FAIL store_ready c%0d got %0b want %0b", c, d_ready_o, c == 6);
      end
      if (c <= 6) begin
        checks++;
        if (mem_stall_o !== (c != 6)) begin
          errors++;
          $display("FAIL store_stall c%0d got %0b want %0b", c, mem_stall_o, c != 6);
        end
      end
      if (c == 6) d_req_i = 1'b0;
    end
    gnt_wait = 0;
  endtask

  task automatic test_reset_mid;
    do_reset();
    auto_en  = 1'b0;
    rsp_data = 64'hBAD0_BAD0_BAD0_BAD0;
    d_req_i  = 1'b1;
    d_addr_i = 64'h5000;
    tick();
    man_gnt = 1'b1;
    tick();
    man_gnt = 1'b0;
    checks++;
    if (dut.state !== RESP) begin
      errors++;
      $display("FAIL mid_resp got %0d want RESP", dut.state);
    end
    #1;
    reset   = 1'b1;
    d_req_i = 1'b0;
    #1;
    checks++;
    if (dut.state !== IDLE || m_req_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_async got st=%0d req=%0b want IDLE/0", dut.state, m_req_o);
    end
    @(posedge clock);
    #1;
    reset      = 1'b0;
    man_rvalid = 1'b1;
    tick();
    man_rvalid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (d_ready_o !== 1'b0 || i_ready_o !== 1'b0 ||
          d_rdata_o !== 64'h0 || dut.state !== IDLE) begin
        errors++;
        $display("FAIL mid_ignore k%0d got dr=%0b ir=%0b rd=%h st=%0d want 0/0/0/IDLE",
                 c, d_ready_o, i_ready_o, d_rdata_o, dut.state);
      end
    end
    auto_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_upper_word();
    test_both();
    test_starve();
    test_flush();
    test_store();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
